// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: definitions shared by the instruction loader and its
// halt-word detector.
//   state_t / ST_*     : loader FSM state encoding (IDLE, LOAD, WRITE, DONE)
//   DEFAULT_HALT_WORD  : big-endian word that terminates a load session
// Optional feature macro used by the loader: LOADER_HALT_DETECT_EN.
package instr_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/halt_word_detector.sv
// halt_word_detector: remembers the last three written bytes and flags a
// word-aligned big-endian match against HALT_WORD.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : empties the history (new session)
//   byte_strobe  : a byte is being written this cycle
//   byte_data    : the byte being written
//   addr_lsb     : low two bits of the write address
//   match        : combinational; high during the write of the last byte of
//                  an aligned word equal to HALT_WORD
module halt_word_detector
  import instr_loader_pkg::*;
#(
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       byte_strobe,
  input  logic [7:0] byte_data,
  input  logic [1:0] addr_lsb,
  output logic       match
);

  logic [23:0] shift_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (clear) begin
      shift_reg <= '0;
    end else if (byte_strobe) begin
      shift_reg <= {shift_reg[15:0], byte_data};
    end
  end

  // Only the byte landing at offset 3 closes a word; earlier offsets would be
  // unaligned matches and are deliberately ignored.
  assign match = byte_strobe && (addr_lsb == 2'd3) && ({shift_reg, byte_data} == HALT_WORD);

endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: drives the instruction memory's byte-wide write port
// from a valid/ready byte stream, starting at address 0, big-endian order.
// Keeps the CPU stalled (o_busy) while a session runs; a session ends on a
// halt word, on writing the last cell, or on i_stop.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_start, i_stop  : begin (IDLE only) / end a session
//   i_byte, i_byte_valid, o_byte_ready : incoming byte handshake
//   o_addr, o_data, o_wr_en            : memory write port
//   o_busy, o_done, o_full, o_byte_count : session status
// Optional feature: define LOADER_HALT_DETECT_EN to enable halt-word
// detection; without it HALT_WORD has no effect.
module instruction_loader
  import instr_loader_pkg::*;
#(
  parameter int          NBITS     = 8,
  parameter int          CELLS     = 256,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  output logic [NBITS-1:0] o_addr,
  output logic [7:0]       o_data,
  output logic             o_wr_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_full,
  output logic [NBITS:0]   o_byte_count
);

  state_t state_reg, state_next;
  logic   stop_pending_reg, stop_pending_next;

  logic             ready_next, wr_en_next, busy_next, done_next, full_next;
  logic [NBITS-1:0] addr_next;
  logic [7:0]       data_next;
  logic [NBITS:0]   count_next;

  logic start_accept, byte_accept, in_write, last_cell, halt_match;

  assign start_accept = (state_reg == ST_IDLE) && i_start;
  assign byte_accept  = (state_reg == ST_LOAD) && o_byte_ready && i_byte_valid;
  assign in_write     = (state_reg == ST_WRITE);
  assign last_cell    = (o_addr == NBITS'(CELLS - 1));

`ifdef LOADER_HALT_DETECT_EN
  // o_data holds the captured byte throughout WRITE, so it is the byte being
  // written and also what gets shifted into the history.
  halt_word_detector #(
    .HALT_WORD(HALT_WORD)
  ) u_halt_word_detector (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .clear      (start_accept),
    .byte_strobe(in_write),
    .byte_data  (o_data),
    .addr_lsb   (o_addr[1:0]),
    .match      (halt_match)
  );
`else
  // Detection compiled out; the reference keeps HALT_WORD part of the
  // parameter list in both builds while contributing a constant 0.
  assign halt_match = HALT_WORD[0] & 1'b0;
`endif

  // State and all outputs are registered together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg        <= ST_IDLE;
      stop_pending_reg <= 1'b0;
      o_byte_ready     <= 1'b0;
      o_addr           <= '0;
      o_data           <= '0;
      o_wr_en          <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_full           <= 1'b0;
      o_byte_count     <= '0;
    end else begin
      state_reg        <= state_next;
      stop_pending_reg <= stop_pending_next;
      o_byte_ready     <= ready_next;
      o_addr           <= addr_next;
      o_data           <= data_next;
      o_wr_en          <= wr_en_next;
      o_busy           <= busy_next;
      o_done           <= done_next;
      o_full           <= full_next;
      o_byte_count     <= count_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next        = state_reg;
    stop_pending_next = 1'b0;
    case (state_reg)
      ST_IDLE:  if (i_start) state_next = ST_LOAD;
      ST_LOAD: begin
        // o_byte_ready is already high here, so a byte offered together with
        // i_stop has been handed over; write it first, then finish.
        if (byte_accept) begin
          state_next        = ST_WRITE;
          stop_pending_next = i_stop;
        end else if (i_stop) begin
          state_next = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (halt_match || last_cell || i_stop || stop_pending_reg) state_next = ST_DONE;
        else                                                        state_next = ST_LOAD;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. Strobes are decoded
  // from state_next so they line up with the state they describe.
  always_comb begin
    ready_next = (state_next == ST_LOAD);
    wr_en_next = (state_next == ST_WRITE);
    busy_next  = (state_next != ST_IDLE);
    done_next  = (state_next == ST_DONE);
    addr_next  = o_addr;
    data_next  = o_data;
    full_next  = o_full;
    count_next = o_byte_count;
    if (start_accept) begin
      addr_next  = '0;
      count_next = '0;
      full_next  = 1'b0;
    end
    if (byte_accept) begin
      data_next = i_byte;
    end
    if (in_write) begin
      count_next = o_byte_count + (NBITS + 1)'(1);
      // The last cell ends the session, so the address parks there instead
      // of wrapping to 0.
      if (last_cell) full_next = 1'b1;
      else           addr_next = o_addr + NBITS'(1);
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed, table-driven check of instruction_loader.
// Builds with or without LOADER_HALT_DETECT_EN; expectations follow the macro.
module tb_instruction_loader;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic [7:0]    i_byte = 8'h00;
  logic          i_byte_valid = 1'b0;
  logic          o_byte_ready;
  logic [NB-1:0] o_addr;
  logic [7:0]    o_data;
  logic          o_wr_en;
  logic          o_busy;
  logic          o_done;
  logic          o_full;
  logic [NB:0]   o_byte_count;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_loader #(
    .NBITS(NB),
    .CELLS(256),
    .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_byte      (i_byte),
    .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready),
    .o_addr      (o_addr),
    .o_data      (o_data),
    .o_wr_en     (o_wr_en),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_full      (o_full),
    .o_byte_count(o_byte_count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]    b;
    logic [NB-1:0] addr;
    logic [NB:0]   count;
    logic          done;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, " wr_en"}, 32'(o_wr_en), 0);
    chk({tag, " ready"}, 32'(o_byte_ready), 0);
    chk({tag, " busy"},  32'(o_busy), 0);
    chk({tag, " done"},  32'(o_done), 0);
    chk({tag, " full"},  32'(o_full), 0);
    chk({tag, " addr"},  32'(o_addr), 0);
    chk({tag, " data"},  32'(o_data), 0);
    chk({tag, " count"}, 32'(o_byte_count), 0);
  endtask

  // Entered and left on a falling edge. Returns in the cycle after the write.
  task automatic send_byte(input logic [7:0] b, input logic [NB-1:0] exp_addr,
                           input logic [NB:0] exp_count);
    int n = 0;
    i_byte = b;
    i_byte_valid = 1'b1;
    while (!o_byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("handshake ready", 32'(o_byte_ready), 1);
    @(negedge clk);
    i_byte_valid = 1'b0;
    chk("write strobe", 32'(o_wr_en), 1);
    chk("write addr", 32'(o_addr), 32'(exp_addr));
    chk("write data", 32'(o_data), 32'(b));
    chk("ready low in write", 32'(o_byte_ready), 0);
    $display("write addr=%0d data=%02h wr_en=%0b", o_addr, o_data, o_wr_en);
    @(negedge clk);
    chk("byte count", 32'(o_byte_count), 32'(exp_count));
  endtask

  task automatic start_session();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("start busy", 32'(o_busy), 1);
    chk("start ready", 32'(o_byte_ready), 1);
    chk("start addr", 32'(o_addr), 0);
    chk("start count", 32'(o_byte_count), 0);
    chk("start full", 32'(o_full), 0);
    $display("session started");
  endtask

  task automatic expect_end(input logic exp_full, input logic [NB:0] exp_count);
    chk("done pulse", 32'(o_done), 1);
    chk("busy during done", 32'(o_busy), 1);
    chk("full at done", 32'(o_full), 32'(exp_full));
    chk("count at done", 32'(o_byte_count), 32'(exp_count));
    @(negedge clk);
    chk("done one cycle", 32'(o_done), 0);
    chk("busy after done", 32'(o_busy), 0);
    chk("full sticky", 32'(o_full), 32'(exp_full));
    $display("session ended count=%0d full=%0b", o_byte_count, o_full);
  endtask

  vec_t tbl[8];

  initial begin
    logic [7:0] bv;

    // Session A vectors: a plain word followed by the aligned halt word.
    tbl[0] = '{8'h01, 8'd0, 9'd1, 1'b0};
    tbl[1] = '{8'h2A, 8'd1, 9'd2, 1'b0};
    tbl[2] = '{8'h58, 8'd2, 9'd3, 1'b0};
    tbl[3] = '{8'h21, 8'd3, 9'd4, 1'b0};
    tbl[4] = '{8'hFF, 8'd4, 9'd5, 1'b0};
    tbl[5] = '{8'hFF, 8'd5, 9'd6, 1'b0};
    tbl[6] = '{8'hFF, 8'd6, 9'd7, 1'b0};
`ifdef LOADER_HALT_DETECT_EN
    tbl[7] = '{8'hFF, 8'd7, 9'd8, 1'b1};
`else
    tbl[7] = '{8'hFF, 8'd7, 9'd8, 1'b0};
`endif

    // Reset state.
    @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("after reset");

    // Session A.
    start_session();
    for (int i = 0; i < 8; i++) begin
      send_byte(tbl[i].b, tbl[i].addr, tbl[i].count);
      chk("table done", 32'(o_done), 32'(tbl[i].done));
      if (!tbl[i].done) chk("table busy", 32'(o_busy), 1);
    end
`ifdef LOADER_HALT_DETECT_EN
    expect_end(1'b0, 9'd8);
`else
    // No halt detection: still loading; end with i_stop in LOAD.
    chk("no halt ready", 32'(o_byte_ready), 1);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    expect_end(1'b0, 9'd8);
`endif

    // i_stop in IDLE is ignored.
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    @(negedge clk);
    chk("idle stop busy", 32'(o_busy), 0);
    chk("idle stop done", 32'(o_done), 0);

    // Session B: unaligned FF run, start-while-busy, back-to-back, stop in WRITE.
    start_session();
    send_byte(8'h00, 8'd0, 9'd1);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("start while busy addr", 32'(o_addr), 1);
    chk("start while busy count", 32'(o_byte_count), 1);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hFF, NB'(i + 1), (NB + 1)'(i + 2));
      chk("unaligned no done", 32'(o_done), 0);
    end
    // Continuous valid: strobe every second cycle, ready alternating.
    bv = 8'h11;
    i_byte = bv;
    i_byte_valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("stream ready", 32'(o_byte_ready), 32'((j % 2) == 0));
      chk("stream wr_en", 32'(o_wr_en), 32'((j % 2) == 1));
      if (j % 2 == 1) begin
        chk("stream addr", 32'(o_addr), 32'(5 + j / 2));
        chk("stream data", 32'(o_data), 32'(bv));
        $display("write addr=%0d data=%02h wr_en=%0b", o_addr, o_data, o_wr_en);
        bv = bv + 8'h11;
        i_byte = bv;
      end
      @(negedge clk);
    end
    i_byte_valid = 1'b0;
    chk("stream count", 32'(o_byte_count), 8);
    // i_stop during WRITE: write completes, then DONE.
    i_byte = 8'h44;
    i_byte_valid = 1'b1;
    @(negedge clk);
    i_byte_valid = 1'b0;
    chk("stop write strobe", 32'(o_wr_en), 1);
    chk("stop write addr", 32'(o_addr), 8);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    expect_end(1'b0, 9'd9);

    // Session C: fill all 256 cells; last aligned word is FF FF FF FF so full
    // and halt coincide in the detecting build and the session ends once.
    start_session();
    for (int i = 0; i < 256; i++) begin
      bv = (i >= 252) ? 8'hFF : 8'(i);
      send_byte(bv, NB'(i), (NB + 1)'(i + 1));
      if (i < 255) chk("fill no done", 32'(o_done), 0);
    end
    expect_end(1'b1, 9'd256);
    chk("addr parks at last cell", 32'(o_addr), 255);

    // Session D: reset during WRITE of the third byte.
    start_session();
    chk("full cleared by start", 32'(o_full), 0);
    send_byte(8'hA0, 8'd0, 9'd1);
    send_byte(8'hA1, 8'd1, 9'd2);
    i_byte = 8'hA2;
    i_byte_valid = 1'b1;
    @(negedge clk);
    i_byte_valid = 1'b0;
    chk("pre-reset strobe", 32'(o_wr_en), 1);
    chk("pre-reset addr", 32'(o_addr), 2);
    rst_n = 1'b0;
    #1;
    check_idle_zero("async reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no done after reset", 32'(o_done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start_session();
    send_byte(8'hAB, 8'd0, 9'd1);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    expect_end(1'b0, 9'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
